// File: rtl/pe_inject_queue.sv
// pe_inject_queue: buffered, token-bucket paced injection stage placed
// between a PE traffic source and the PE input port of a torus switch.
// Source bursts land in a first-word-fall-through FIFO. The head packet is
// offered to the switch only while the bucket holds a token, and it is held
// stable until the switch takes it.
module pe_inject_queue #(
  parameter int P_W       = 22,
  parameter int FIFO_D    = 8,
  parameter int MAX_RATE  = 1,
  parameter int MAX_TOKEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [P_W-1:0]            src_pkt,
  input  logic                      src_vld,
  output logic                      src_rdy,
  output logic [P_W-1:0]            out_pkt,
  output logic                      out_vld,
  input  logic                      sw_rdy,
  output logic [$clog2(FIFO_D):0]   occupancy,
  output logic [CNT_W-1:0]          sent_cnt
);

  // Storage and pointer geometry (FIFO_D is a power of two, so pointers wrap naturally)
  localparam int AW    = $clog2(FIFO_D);
  localparam int OCC_W = AW + 1;

  // Token bucket geometry; the refill counter keeps one bit even when MAX_RATE is 1
  localparam int TK_W = $clog2(MAX_TOKEN + 1);
  localparam int RC_W = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;

  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_D);
  localparam logic [AW-1:0]    PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [TK_W-1:0]  TOK_ZERO = {TK_W{1'b0}};
  localparam logic [TK_W-1:0]  TOK_ONE  = TK_W'(1);
  localparam logic [TK_W-1:0]  TOK_MAX  = TK_W'(MAX_TOKEN);
  localparam logic [RC_W-1:0]  RC_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(MAX_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Registered state
  logic [P_W-1:0]   mem_r [FIFO_D];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [TK_W-1:0]  tokens_r;
  logic [RC_W-1:0]  refill_cnt_r;
  logic [CNT_W-1:0] sent_cnt_r;

  // Combinational control
  logic             full_s;
  logic             empty_s;
  logic             tok_avail_s;
  logic             push_s;
  logic             pop_s;
  logic             refill_s;
  logic [OCC_W-1:0] occ_nxt_s;
  logic [TK_W-1:0]  tokens_nxt_s;
  logic [RC_W-1:0]  refill_cnt_nxt_s;

  // Handshake decode: both ready and valid come from registered state only,
  // so neither sw_rdy nor src_vld can loop back through this block.
  always_comb begin
    full_s      = (occ_r == OCC_FULL);
    empty_s     = (occ_r == OCC_ZERO);
    tok_avail_s = (tokens_r != TOK_ZERO);
    src_rdy     = !full_s;
    out_vld     = !empty_s && tok_avail_s;
    push_s      = src_vld && !full_s;
    pop_s       = out_vld && sw_rdy;
    refill_s    = (refill_cnt_r == RC_LAST);
  end

  // Occupancy next state: a simultaneous push and pop leaves the level unchanged
  always_comb begin
    occ_nxt_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE;
      2'b11:   occ_nxt_s = occ_r;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Bucket next state: a refill and a consume in the same cycle cancel, so no
  // token is lost to saturation; a lone refill saturates at MAX_TOKEN.
  always_comb begin
    tokens_nxt_s = tokens_r;
    case ({refill_s, pop_s})
      2'b10: begin
        if (tokens_r != TOK_MAX) begin
          tokens_nxt_s = tokens_r + TOK_ONE;
        end else begin
          tokens_nxt_s = tokens_r;
        end
      end
      2'b01:   tokens_nxt_s = tokens_r - TOK_ONE;
      2'b11:   tokens_nxt_s = tokens_r;
      default: tokens_nxt_s = tokens_r;
    endcase
  end

  // Refill counter free-runs 0..MAX_RATE-1 from reset, independent of traffic
  always_comb begin
    if (refill_s) begin
      refill_cnt_nxt_s = RC_ZERO;
    end else begin
      refill_cnt_nxt_s = refill_cnt_r + RC_ONE;
    end
  end

  // Packet storage: written at the tail on an accepted push, never during reset
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= src_pkt;
    end
  end

  // FIFO pointers and occupancy; reset drops every stored packet
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      occ_r <= occ_nxt_s;
    end
  end

  // Token bucket state: starts full so the first MAX_TOKEN packets go back to back
  always_ff @(posedge clk) begin
    if (rst) begin
      tokens_r     <= TOK_MAX;
      refill_cnt_r <= RC_ZERO;
    end else begin
      tokens_r     <= tokens_nxt_s;
      refill_cnt_r <= refill_cnt_nxt_s;
    end
  end

  // Accepted-packet counter; wraps silently at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_cnt_r <= CNT_ZERO;
    end else if (pop_s) begin
      sent_cnt_r <= sent_cnt_r + CNT_ONE;
    end
  end

  // Output mapping: the head entry falls through, and it stays put until popped
  always_comb begin
    out_pkt   = mem_r[rd_ptr_r];
    occupancy = occ_r;
    sent_cnt  = sent_cnt_r;
  end

endmodule

// File: tb/tb_pe_inject_queue.sv
// Bench for pe_inject_queue. Instance A uses the default pacing (a token every
// cycle) and is driven from a vector table followed by a full-queue hold
// sequence. Instance B uses MAX_RATE=4, MAX_TOKEN=2 and a 3-bit counter to
// check pacing, same-cycle refill/consume and counter wrap.
module tb_pe_inject_queue;

  logic clk;

  // Instance A signals
  logic        a_rst, a_src_vld, a_src_rdy, a_out_vld, a_sw_rdy;
  logic [21:0] a_src_pkt, a_out_pkt;
  logic [3:0]  a_occ;
  logic [15:0] a_sent;

  // Instance B signals
  logic        b_rst, b_src_vld, b_src_rdy, b_out_vld, b_sw_rdy;
  logic [21:0] b_src_pkt, b_out_pkt;
  logic [3:0]  b_occ;
  logic [2:0]  b_sent;

  int n_vec = 0;
  int n_err = 0;

  logic [21:0] a_sbq[$];
  logic [21:0] b_sbq[$];

  typedef struct {
    logic        rst;
    logic        vld;
    logic [21:0] pkt;
    logic        sw;
    logic        e_rdy;
    logic        e_vld;
    logic [3:0]  e_occ;
    logic [15:0] e_sent;
  } vec_t;

  vec_t tv[$];

  pe_inject_queue #(.P_W(22), .FIFO_D(8), .MAX_RATE(1), .MAX_TOKEN(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst), .src_pkt(a_src_pkt), .src_vld(a_src_vld), .src_rdy(a_src_rdy),
    .out_pkt(a_out_pkt), .out_vld(a_out_vld), .sw_rdy(a_sw_rdy),
    .occupancy(a_occ), .sent_cnt(a_sent)
  );

  pe_inject_queue #(.P_W(22), .FIFO_D(8), .MAX_RATE(4), .MAX_TOKEN(2), .CNT_W(3)) u_b (
    .clk(clk), .rst(b_rst), .src_pkt(b_src_pkt), .src_vld(b_src_vld), .src_rdy(b_src_rdy),
    .out_pkt(b_out_pkt), .out_vld(b_out_vld), .sw_rdy(b_sw_rdy),
    .occupancy(b_occ), .sent_cnt(b_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [21:0] p, input logic s,
                     input logic rdy, input logic ov, input logic [3:0] occ, input logic [15:0] sent);
    vec_t t;
    t.rst = r; t.vld = v; t.pkt = p; t.sw = s;
    t.e_rdy = rdy; t.e_vld = ov; t.e_occ = occ; t.e_sent = sent;
    tv.push_back(t);
  endtask

  // Drive instance A for one cycle, away from the rising edge
  task automatic a_drive(input logic r, input logic v, input logic [21:0] p, input logic s);
    @(negedge clk);
    a_rst = r; a_src_vld = v; a_src_pkt = p; a_sw_rdy = s;
    #1;
  endtask

  // Scoreboard for instance A: predicts what happens at the coming edge
  task automatic a_sb();
    if (a_rst) begin
      a_sbq.delete();
    end else begin
      if (a_out_vld && a_sw_rdy) begin
        if (a_sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_sb_underflow: got accept of %0h, expected no packet", a_out_pkt);
        end else begin
          chk("a_out_pkt", {10'd0, a_out_pkt}, {10'd0, a_sbq.pop_front()});
        end
      end
      if (a_src_vld && a_src_rdy) a_sbq.push_back(a_src_pkt);
    end
  endtask

  initial begin
    logic [21:0] pk;
    logic        vld;
    logic        sw;
    int          acc[$];
    int          exp_acc[8];

    a_rst = 1'b1; a_src_vld = 1'b0; a_src_pkt = 22'h0; a_sw_rdy = 1'b0;
    b_rst = 1'b1; b_src_vld = 1'b0; b_src_pkt = 22'h0; b_sw_rdy = 1'b0;

    // ---------------- vector table for instance A ----------------
    // Fields: rst, vld, pkt, sw_rdy | expected src_rdy, out_vld, occupancy, sent_cnt
    // Expected outputs are those visible in the cycle the inputs are applied.
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b0, 4'd0, 16'd0);    // reset state
    add(1'b0, 1'b1, 22'h2A5A5, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0);    // single push
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b1, 4'd1, 16'd0);    // offered next cycle, accepted
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b0, 4'd0, 16'd1);
    for (int k = 0; k < 8; k++)                                    // fill with switch stalled
      add(1'b0, 1'b1, 22'h100A0 + 22'(k), 1'b0, 1'b1, (k > 0), 4'(k), 16'd1);
    add(1'b0, 1'b1, 22'h3FFFF, 1'b0, 1'b0, 1'b1, 4'd8, 16'd1);    // 9th dropped
    add(1'b0, 1'b1, 22'h3FFFF, 1'b1, 1'b0, 1'b1, 4'd8, 16'd1);    // full: pop only
    add(1'b0, 1'b1, 22'h155AA, 1'b0, 1'b1, 1'b1, 4'd7, 16'd2);    // freed slot taken
    add(1'b0, 1'b0, 22'h0,     1'b0, 1'b0, 1'b1, 4'd8, 16'd2);
    for (int k = 0; k < 8; k++)                                    // drain back to back
      add(1'b0, 1'b0, 22'h0, 1'b1, (k != 0), 1'b1, 4'(8 - k), 16'(2 + k));
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b0, 4'd0, 16'd10);
    add(1'b0, 1'b1, 22'h0AAAA, 1'b1, 1'b1, 1'b0, 4'd0, 16'd10);   // push+pop streaming
    add(1'b0, 1'b1, 22'h0BBBB, 1'b1, 1'b1, 1'b1, 4'd1, 16'd10);
    add(1'b0, 1'b1, 22'h0CCCC, 1'b1, 1'b1, 1'b1, 4'd1, 16'd11);
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b1, 4'd1, 16'd12);
    add(1'b0, 1'b0, 22'h0,     1'b0, 1'b1, 1'b0, 4'd0, 16'd13);
    for (int k = 0; k < 5; k++)                                    // build up 5 entries
      add(1'b0, 1'b1, 22'h2E000 + 22'(k), 1'b0, 1'b1, (k > 0), 4'(k), 16'd13);
    add(1'b1, 1'b1, 22'h3C3C3, 1'b0, 1'b1, 1'b1, 4'd5, 16'd13);   // reset mid-burst
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
    add(1'b0, 1'b0, 22'h0,     1'b1, 1'b1, 1'b0, 4'd0, 16'd0);

    a_drive(1'b1, 1'b0, 22'h0, 1'b0);
    a_drive(1'b1, 1'b0, 22'h0, 1'b0);
    a_sbq.delete();

    foreach (tv[i]) begin
      a_drive(tv[i].rst, tv[i].vld, tv[i].pkt, tv[i].sw);
      chk($sformatf("v%0d_src_rdy", i),   {31'd0, a_src_rdy}, {31'd0, tv[i].e_rdy});
      chk($sformatf("v%0d_out_vld", i),   {31'd0, a_out_vld}, {31'd0, tv[i].e_vld});
      chk($sformatf("v%0d_occupancy", i), {28'd0, a_occ},     {28'd0, tv[i].e_occ});
      chk($sformatf("v%0d_sent_cnt", i),  {16'd0, a_sent},    {16'd0, tv[i].e_sent});
      a_sb();
    end

    // ---------------- A: full queue holds its head for 20 cycles ----------------
    for (int k = 0; k < 8; k++) begin
      a_drive(1'b0, 1'b1, 22'h31100 + 22'(k), 1'b0);
      a_sb();
    end
    for (int c = 0; c < 20; c++) begin
      a_drive(1'b0, 1'b1, 22'h3FFFF, 1'b0);
      chk("hold_out_vld", {31'd0, a_out_vld}, 32'd1);
      chk("hold_out_pkt", {10'd0, a_out_pkt}, {10'd0, 22'h31100});
      chk("hold_src_rdy", {31'd0, a_src_rdy}, 32'd0);
      chk("hold_occupancy", {28'd0, a_occ}, 32'd8);
      a_sb();
    end
    for (int c = 0; c < 12; c++) begin
      a_drive(1'b0, 1'b0, 22'h0, 1'b1);
      a_sb();
    end
    chk("drain_occupancy", {28'd0, a_occ}, 32'd0);
    chk("drain_sb_empty", a_sbq.size(), 32'd0);
    chk("drain_sent_cnt", {16'd0, a_sent}, 32'd8);

    // ---------------- B: pacing with MAX_RATE=4, MAX_TOKEN=2 ----------------
    // The reset edge is edge 0; refills then land on edges 4, 8, 12, ...
    // Switch opens at edge 10 (two edges before a refill): two accepts on
    // the full bucket (10, 11), then the refill on 12 gives an accept on 13,
    // and one every 4 edges after that. Later, with one token left, an accept
    // on refill edge 32 keeps the token so edge 33 accepts immediately.
    // Eight accepts wrap the 3-bit counter back to 0.
    exp_acc = '{10, 11, 13, 17, 21, 25, 32, 33};
    @(negedge clk);
    b_rst = 1'b1; b_src_vld = 1'b0; b_sw_rdy = 1'b0;
    #1;
    b_sbq.delete();
    for (int i = 1; i <= 40; i++) begin
      vld = (i <= 6) || (i == 29) || (i == 30);
      pk  = vld ? (22'h2B000 + 22'(i)) : 22'h0;
      sw  = ((i >= 10) && (i <= 28)) || (i >= 32);
      @(negedge clk);
      b_rst = 1'b0; b_src_vld = vld; b_src_pkt = pk; b_sw_rdy = sw;
      #1;
      if (i == 1) begin
        chk("b_reset_out_vld", {31'd0, b_out_vld}, 32'd0);
        chk("b_reset_sent", {29'd0, b_sent}, 32'd0);
      end
      if (i == 10) chk("b_burst_occupancy", {28'd0, b_occ}, 32'd6);
      if (i == 12) chk("b_bucket_empty_out_vld", {31'd0, b_out_vld}, 32'd0);
      if (i == 26) chk("b_sent_after_six", {29'd0, b_sent}, 32'd6);
      if (i == 27) chk("b_idle_out_vld", {31'd0, b_out_vld}, 32'd0);
      if (i == 34) chk("b_sent_wrapped", {29'd0, b_sent}, 32'd0);
      if (b_out_vld && b_sw_rdy) begin
        acc.push_back(i);
        if (b_sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_sb_underflow: got accept of %0h, expected no packet", b_out_pkt);
        end else begin
          chk("b_out_pkt", {10'd0, b_out_pkt}, {10'd0, b_sbq.pop_front()});
        end
      end
      if (b_src_vld && b_src_rdy) b_sbq.push_back(b_src_pkt);
    end
    chk("b_accept_count", acc.size(), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < acc.size()) chk($sformatf("b_accept_edge%0d", k), acc[k], exp_acc[k]);
    end
    chk("b_sb_empty", b_sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
